hex_scan_display: RTL
=====================

# hex_scan_display

Parametrised, time-multiplexed hex display driver for the single-cycle processor's debug board. It takes NUM_CH 32-bit debug words (PC, selected register, instruction, ALU result, and so on) and splits them into pages of NUM_DIGITS nibbles. It scans those nibbles onto a shared seven-segment bus with per-digit anode enables. The page is selected by a stepping button or by automatic dwell-timed rotation, and a freeze input holds a stable snapshot while the core keeps running.

## Interface
- NUM_CH, 3: number of 32-bit input channels, at least 1.
- NUM_DIGITS, 4: physical digits; must be 1, 2, 4 or 8.
- SCAN_DIV, 50000: clock cycles each digit stays selected; at least 2.
- DWELL, 50000000: clock cycles per page in auto mode; at least 1.
- SEG_ACTIVE_LOW, 1: 1 means segments and anodes are active-low; 0 inverts both.
- Derived: PPC = 8/NUM_DIGITS pages per channel; NPAGES = NUM_CH*PPC; PW = max(1, clog2(NPAGES)).
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- data_in  in  NUM_CH*32  channel k occupies bits [32k+31:32k].
- sel_step  in  1  step request, already synchronised and debounced; acts on its rising edge.
- auto_en  in  1  enables dwell-timed page rotation.
- freeze  in  1  while high, the displayed snapshot is held.
- seg  out  7  segments {g,f,e,d,c,b,a}.
- an  out  NUM_DIGITS  digit enables; bit 0 drives the rightmost digit.
- page  out  PW  current page index.

## Operation
- **Page mapping:** page p shows channel p/PPC, nibble group p%PPC. Group 0 is the least-significant NUM_DIGITS nibbles. Digit d shows nibble (p%PPC)*NUM_DIGITS + d of that channel.
- **Snapshot register (NUM_CH*32 bits):**
  - Loads data_in every cycle while freeze=0.
  - Holds its value while freeze=1.
  - The display always reads the snapshot, never data_in directly.
- **Step edge detection:** sel_step is registered once; step = sel_step & ~sel_step_q.
- **Dwell counter:**
  - Counts only while auto_en=1.
  - On reaching DWELL-1 it clears to 0 and raises a one-cycle tick.
  - Clears to 0 on any step, and whenever auto_en=0.
- **Page register:**
  - Increments on step or tick, wrapping from NPAGES-1 to 0.
  - If step and tick occur in the same cycle, the page advances by exactly 1.
  - While freeze=1, the page still advances; only the data is held.
- **Scan FSM, states SCAN and BLANK:**
  - A divider counts 0 to SCAN_DIV-1.
  - At terminal count, the digit index advances (mod NUM_DIGITS) and the FSM enters BLANK for exactly 1 cycle, with all anodes off (anti-ghosting). It then returns to SCAN.
  - In SCAN, exactly one anode is on (bit = digit index), and seg shows hex_to_7seg of the selected nibble.
- **Polarity:** with SEG_ACTIVE_LOW=0, seg and an are bitwise inverted.
- **Reset values** (active-low case):
  - page=0, digit index=0, both counters=0, state=BLANK.
  - an all 1s (off), seg=7'h7F (blank), snapshot=0, sel_step_q=0.
- **Reset mid-operation:** counters and page clear immediately and asynchronously, and the outputs blank.

## Timing
- seg and an are registered. They reflect the state (page, digit, snapshot) of the previous cycle.
- data_in change to visible seg (freeze=0, digit already selected): 2 cycles (snapshot, then output register).
- step to page output: page updates 1 cycle after the cycle in which the rising edge is registered.
- step to seg reflecting the new page: 1 further cycle if the digit is in SCAN.
- After the first cycle out of reset, the sequence is 1 BLANK cycle, then SCAN on digit 0 for SCAN_DIV cycles. In steady state each full digit slot is SCAN_DIV+1 cycles.
- Holding sel_step high steps the page only once.

## Structure
- Shared package disp_pkg holds:
  - the 16-entry hex-to-segment constant table, active-low {g..a} (0 = 7'h40, F = 7'h0E);
  - SEG_BLANK = 7'h7F;
  - the scan state enum {SCAN, BLANK}.
- Reuse the existing hex_to_7seg as the single sub-module instance, fed by the nibble mux.
- The top level contains the snapshot, step detector, dwell counter, page register, scan FSM/divider and output registers.

## Test plan
All scenarios use NUM_CH=3, NUM_DIGITS=4, SCAN_DIV=4, DWELL=64.
- **Reset and scan:** release rst with data_in = {32'h0, 32'h0, 32'h0000_1234}.
  - an cycles 1110, 1101, 1011, 0111, each for 4 cycles, separated by single 1111 cycles.
  - seg shows 4, 3, 2, 1 (7'h19, 7'h30, 7'h24, 7'h79).
- **Paging:** pulse sel_step 5 times.
  - page goes 1, 2, 3, 4, 5; a 6th pulse wraps it to 0.
  - On page 1 with channel 0 = 32'hDEAD_1234, the digits show D, E, A, D.
- **Held step:** hold sel_step high for 20 cycles; page increments exactly once.
- **Auto rotation:** auto_en=1, no steps; page advances every 64 cycles.
  - A step at count 30 advances the page and restarts the 64-cycle count.
  - A step coinciding with the tick advances the page by exactly 1.
- **Freeze:** set freeze=1 with the display showing 1234, then change data_in to 32'hFFFF_FFFF.
  - The digits stay 1234.
  - After freeze=0, they show F within 2 cycles of the digit being selected.
- **Asynchronous reset mid-scan:** assert rst between clock edges while on page 3, digit 2.
  - Immediately: page=0, an=1111, seg=7'h7F.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared definitions for the debug-board hex display: segment codes and scan states.
package disp_pkg;

  typedef enum logic {
    SCAN  = 1'b0,
    BLANK = 1'b1
  } scan_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_7seg
  import disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/hex_scan_display.sv
// Paged, time-multiplexed hex display of NUM_CH 32-bit debug words with step,
// dwell-timed auto rotation and freeze.
module hex_scan_display
  import disp_pkg::*;
#(
  parameter  int NUM_CH         = 3,
  parameter  int NUM_DIGITS     = 4,
  parameter  int SCAN_DIV       = 50000,
  parameter  int DWELL          = 50000000,
  parameter  int SEG_ACTIVE_LOW = 1,
  localparam int PPC            = 8 / NUM_DIGITS,
  localparam int NPAGES         = NUM_CH * PPC,
  localparam int PW             = (NPAGES > 1) ? $clog2(NPAGES) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*32-1:0]     data_in,
  input  logic                     sel_step,
  input  logic                     auto_en,
  input  logic                     freeze,
  output logic [6:0]               seg,
  output logic [NUM_DIGITS-1:0]    an,
  output logic [PW-1:0]            page
);

  localparam int DW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SH   = $clog2(NUM_DIGITS);
  localparam int IW   = PW + DW;
  localparam int NNIB = NUM_CH * 8;
  localparam int CW   = $clog2(SCAN_DIV);
  localparam int TW   = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [6:0]            SEG_XOR = (SEG_ACTIVE_LOW != 0) ? 7'h00 : 7'h7F;
  localparam logic [NUM_DIGITS-1:0] AN_XOR  = (SEG_ACTIVE_LOW != 0) ? '0 : '1;
  localparam logic [6:0]            SEG_OFF = SEG_BLANK ^ SEG_XOR;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{1'b1}} ^ AN_XOR;

  logic [NUM_CH*32-1:0]  snapshot;
  logic                  sel_step_q;
  logic                  step;
  logic                  tick;
  logic [TW-1:0]         dwell_cnt;
  scan_state_t           state;
  logic [CW-1:0]         div_cnt;
  logic [DW-1:0]         digit;
  logic [3:0]            nibs [2**IW];
  logic [IW-1:0]         nib_sel;
  logic [6:0]            seg_code;
  logic [NUM_DIGITS-1:0] onehot;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          snapshot <= '0;
    else if (!freeze) snapshot <= data_in;
  end

  assign step = sel_step & ~sel_step_q;
  assign tick = auto_en && (dwell_cnt == TW'(DWELL - 1));

  // A simultaneous step and tick still advance the page by a single position
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_step_q <= 1'b0;
      dwell_cnt  <= '0;
      page       <= '0;
    end else begin
      sel_step_q <= sel_step;
      if (!auto_en || step || tick) dwell_cnt <= '0;
      else                          dwell_cnt <= dwell_cnt + 1'b1;
      if (step || tick)
        page <= (page == PW'(NPAGES - 1)) ? '0 : page + 1'b1;
    end
  end

  // Page p, digit d maps to linear nibble p*NUM_DIGITS + d of the snapshot
  always_comb begin
    for (int i = 0; i < NNIB; i++)
      nibs[i] = snapshot[i*4 +: 4];
    for (int i = NNIB; i < 2**IW; i++)
      nibs[i] = 4'h0;
  end

  assign nib_sel = (IW'(page) << SH) | IW'(digit);
  assign onehot  = NUM_DIGITS'(1) << digit;

  hex_to_7seg u_hex (
    .nibble (nibs[nib_sel]),
    .seg    (seg_code)
  );

  // One BLANK cycle separates digit slots so the old pattern never ghosts onto the next anode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= BLANK;
      div_cnt <= '0;
      digit   <= '0;
      seg     <= SEG_OFF;
      an      <= AN_OFF;
    end else begin
      case (state)
        SCAN: begin
          seg <= seg_code ^ SEG_XOR;
          an  <= ~onehot ^ AN_XOR;
          if (div_cnt == CW'(SCAN_DIV - 1)) begin
            div_cnt <= '0;
            digit   <= (digit == DW'(NUM_DIGITS - 1)) ? '0 : digit + 1'b1;
            state   <= BLANK;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: begin
          seg   <= SEG_OFF;
          an    <= AN_OFF;
          state <= SCAN;
        end
      endcase
    end
  end

endmodule
